// File: rtl/branch_resolve_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_if
// Bundle between the pipeline and the branch resolve unit.
//   master : pipeline side. Drives the EX-stage branch (ex_*), the flush and
//            the fetch lookup PC. Receives the prediction and the result.
//   slave  : branch_resolve_unit side. Receives the EX-stage branch and the
//            lookup PC. Drives if_pred_taken and the registered res_* result.
// ----------------------------------------------------------------------------
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            flush;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [XLEN-1:0] res_redirect_pc;
    logic            res_illegal;

    modport master (
        output ex_valid, ex_is_branch, ex_funct3, ex_a, ex_b, ex_pc,
               ex_target, ex_pred_taken, flush, if_pc,
        input  if_pred_taken, res_valid, res_taken, res_mispredict,
               res_redirect_pc, res_illegal
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_funct3, ex_a, ex_b, ex_pc,
               ex_target, ex_pred_taken, flush, if_pc,
        output if_pred_taken, res_valid, res_taken, res_mispredict,
               res_redirect_pc, res_illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves the RV32I/RV64I B-type condition of the EX-stage instruction,
// compares it with the fetch-time prediction and reports the outcome,
// mispredict and correct next PC one cycle later. Owns a table of 2-bit
// saturating counters that fetch reads combinationally and that every
// resolved legal branch trains.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - branch_resolve_if.slave: ex_* / flush / if_pc in,
//          if_pred_taken (combinational) and res_* (registered) out
//
// Optional build macro BRU_BHT_BYPASS_EN: when defined, a fetch lookup that
// hits the counter being trained in the same cycle sees the updated value.
// When undefined the lookup always returns the stored (old) counter.
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input logic              clk,
    input logic              rst,
    branch_resolve_if.slave  bus
);
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]           bht_r [BHT_ENTRIES];
    logic                 accept_s;
    logic                 taken_s;
    logic                 illegal_s;
    logic                 update_en_s;
    logic [BHT_IDX_W-1:0] ex_idx_s;
    logic [BHT_IDX_W-1:0] if_idx_s;
    logic [1:0]           cnt_old_s;
    logic [1:0]           cnt_new_s;
    logic [XLEN-1:0]      redirect_s;
    logic                 if_pred_s;

    logic                 res_valid_r;
    logic                 res_taken_r;
    logic                 res_mispredict_r;
    logic [XLEN-1:0]      res_redirect_pc_r;
    logic                 res_illegal_r;

    assign accept_s = bus.ex_valid && !bus.flush;
    assign ex_idx_s = bus.ex_pc[BHT_IDX_W+1:2];
    assign if_idx_s = bus.if_pc[BHT_IDX_W+1:2];

    // Branch condition evaluation keyed on funct3.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        if (bus.ex_is_branch) begin
            case (bus.ex_funct3)
                3'b000:  taken_s = (bus.ex_a == bus.ex_b);
                3'b001:  taken_s = (bus.ex_a != bus.ex_b);
                3'b100:  taken_s = ($signed(bus.ex_a) <  $signed(bus.ex_b));
                3'b101:  taken_s = ($signed(bus.ex_a) >= $signed(bus.ex_b));
                3'b110:  taken_s = (bus.ex_a <  bus.ex_b);
                3'b111:  taken_s = (bus.ex_a >= bus.ex_b);
                3'b010,
                3'b011:  illegal_s = 1'b1;
                default: begin
                    taken_s   = 1'b0;
                    illegal_s = 1'b0;
                end
            endcase
        end else begin
            taken_s   = 1'b0;
            illegal_s = 1'b0;
        end
    end

    // Next PC: target when taken, fall-through otherwise (wraps naturally).
    assign redirect_s = taken_s ? bus.ex_target : (bus.ex_pc + XLEN'(4));

    // Saturating counter step for the entry addressed by the EX-stage PC.
    always_comb begin
        cnt_old_s = bht_r[ex_idx_s];
        if (taken_s) begin
            cnt_new_s = (cnt_old_s == 2'b11) ? 2'b11 : (cnt_old_s + 2'd1);
        end else begin
            cnt_new_s = (cnt_old_s == 2'b00) ? 2'b00 : (cnt_old_s - 2'd1);
        end
    end

    assign update_en_s = accept_s && bus.ex_is_branch && !illegal_s;

    // Fetch-side prediction lookup, optionally forwarding a same-cycle update.
    always_comb begin
`ifdef BRU_BHT_BYPASS_EN
        if (update_en_s && (if_idx_s == ex_idx_s)) begin
            if_pred_s = cnt_new_s[1];
        end else begin
            if_pred_s = bht_r[if_idx_s][1];
        end
`else
        if_pred_s = bht_r[if_idx_s][1];
`endif
    end

    assign bus.if_pred_taken = if_pred_s;

    // Branch history table: reset to weakly not-taken, train on legal branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (update_en_s) begin
            bht_r[ex_idx_s] <= cnt_new_s;
        end
    end

    // Result registers: valid follows accept, payload holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r       <= 1'b0;
            res_taken_r       <= 1'b0;
            res_mispredict_r  <= 1'b0;
            res_redirect_pc_r <= '0;
            res_illegal_r     <= 1'b0;
        end else begin
            res_valid_r <= accept_s;
            if (accept_s) begin
                res_taken_r       <= taken_s;
                res_mispredict_r  <= (taken_s != bus.ex_pred_taken);
                res_redirect_pc_r <= redirect_s;
                res_illegal_r     <= illegal_s;
            end
        end
    end

    assign bus.res_valid       = res_valid_r;
    assign bus.res_taken       = res_taken_r;
    assign bus.res_mispredict  = res_mispredict_r;
    assign bus.res_redirect_pc = res_redirect_pc_r;
    assign bus.res_illegal     = res_illegal_r;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch-condition check.
- Evaluates the RV32I/RV64I B-type condition for the EX-stage instruction, compares the result against the fetch-time prediction, and raises a mispredict with the redirect PC one cycle later.
- Owns a 2-bit saturating branch history table (BHT). IF reads the table combinationally; the unit trains it on every resolved branch.

Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- BHT_ENTRIES, 64, number of BHT counters; must be a power of two, minimum 2.
- BHT_IDX_W, $clog2(BHT_ENTRIES), index width; derived, never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX-stage instruction valid
- ex_is_branch  in  1  instruction is B-type
- ex_funct3  in  3  branch funct3
- ex_a  in  XLEN  rs1 value
- ex_b  in  XLEN  rs2 value
- ex_pc  in  XLEN  instruction PC
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  prediction made at fetch
- flush  in  1  kill the EX-stage instruction this cycle
- if_pc  in  XLEN  fetch PC for BHT lookup
- if_pred_taken  out  1  combinational prediction: selected counter MSB
- res_valid  out  1  registered result valid
- res_taken  out  1  registered actual outcome
- res_mispredict  out  1  registered mispredict
- res_redirect_pc  out  XLEN  registered correct next PC
- res_illegal  out  1  registered: branch with reserved funct3 (010/011)

Behaviour:
- Reset: res_valid, res_taken, res_mispredict and res_illegal go to 0; res_redirect_pc goes to 0; every BHT counter goes to 2'b01 (weakly not-taken). All of this happens in the single reset cycle.
- Input qualification: accept = ex_valid && !flush. If accept is 0 on an edge, res_valid goes to 0, the other res_* outputs hold their values, and the BHT is not written.
- Conditions, keyed on funct3:
  - 000 BEQ: a==b
  - 001 BNE: a!=b
  - 100 BLT: signed a<b
  - 101 BGE: signed a>=b
  - 110 BLTU: unsigned a<b
  - 111 BGEU: unsigned a>=b
  - 010/011: not taken, and res_illegal=1
- Signed compares use the full XLEN width.
- Non-branch instruction (ex_is_branch=0): taken=0 and illegal=0.
- mispredict = (taken != ex_pred_taken). For a non-branch this flags a false predicted-taken.
- redirect_pc = taken ? ex_target : ex_pc + 4. The add wraps modulo 2^XLEN.
- Latency: exactly one cycle, input edge to res_*. No backpressure.
- BHT index = pc[BHT_IDX_W+1:2].
- BHT update: on an edge where accept && ex_is_branch && !illegal, the counter at ex_pc's index changes.
  - Taken: +1, saturating at 3.
  - Not taken: -1, saturating at 0.
- Illegal branches and non-branches never update the BHT.
- Flush and update in the same cycle: flush wins; no update and no result.
- Lookup/update collision (if_pc and ex_pc map to the same index in the same cycle): if_pred_taken returns the pre-update counter, unless the bypass feature below is compiled in.
- Reset asserted mid-stream: reset wins over any simultaneous accept; the in-flight result is dropped.

Optional Feature:
- Macro BRU_BHT_BYPASS_EN.
- Defined: on a lookup/update index collision, if_pred_taken reflects the post-update counter MSB in the same cycle. This is combinational forwarding.
- Undefined: if_pred_taken always reads the stored counter, i.e. the old value on a collision.
- All other behaviour is identical in both builds.

Test Plan:
- All funct3 encodings: a=32'hFFFF_FFFF, b=1.
  - BLT -> taken=1; BLTU -> 0; BGE -> 0; BGEU -> 1; BEQ -> 0; BNE -> 1.
  - funct3=010 -> taken=0, illegal=1, BHT unchanged.
- Mispredict/redirect: BEQ a=b=5, pc=0x100, target=0x80, pred=0 -> next cycle valid=1, taken=1, mispredict=1, redirect=0x80. Same operands with pred=1 -> mispredict=0.
- Not-taken redirect wrap: BNE a=b, pc=0xFFFF_FFFC, pred=1 -> mispredict=1, redirect=0x0000_0000.
- BHT saturation:
  - After reset, if_pc=0x40 -> pred=0.
  - Three taken branches at pc=0x40 -> counter 3, pred=1.
  - A fourth taken -> counter stays 3.
  - Three not-taken -> counter 0; a fourth -> counter stays 0.
  - pc=0x140 aliases to the same index when BHT_ENTRIES=64.
- Flush: taken BEQ with flush=1 -> res_valid=0 next cycle, BHT counter unchanged. rst asserted during a stream of valid branches -> all outputs 0 and all counters 01 on the next cycle.
- Collision: counter at index of 0x40 is 1; taken branch at ex_pc=0x40 while if_pc=0x40 -> if_pred_taken=0 without BRU_BHT_BYPASS_EN, 1 with it; the following cycle reads 1 in both builds.
